// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: constants and types shared by the IF stage and the IF/ID register.
// rev 1.0
`default_nettype none

package riscv_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_7013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, fetches one word at a time over req/ack and buffers it for IF/ID.
// rev 1.0
`default_nettype none

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = riscv_pipe_pkg::NOP_INSTR,
   parameter logic [31:0] PC_STEP   = riscv_pipe_pkg::PC_STEP
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_IFIDWrite,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_instr,
   output logic        o_if_valid,
   output logic        o_fetch_busy
);

   import riscv_pipe_pkg::*;

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  req_pc, req_pc_nxt;
   logic [31:0]  buf_pc, buf_pc_nxt;
   logic [31:0]  buf_instr, buf_instr_nxt;
   logic [31:0]  target;

   assign target = i_redirect_pc & ~32'h0000_0003;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_pc    <= RESET_PC;
         buf_pc    <= RESET_PC;
         buf_instr <= NOP_INSTR;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         req_pc    <= req_pc_nxt;
         buf_pc    <= buf_pc_nxt;
         buf_instr <= buf_instr_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      req_pc_nxt    = req_pc;
      buf_pc_nxt    = buf_pc;
      buf_instr_nxt = buf_instr;
      case (state)
         IDLE: begin
            state_nxt = FETCH;
            if (i_redirect) begin
               pc_nxt     = target;
               req_pc_nxt = target;
            end else begin
               req_pc_nxt = pc;
            end
         end
         FETCH: begin
            if (i_redirect && i_imem_ack) begin
               pc_nxt     = target;
               req_pc_nxt = target;
            end else if (i_redirect) begin
               // the in-flight request cannot be withdrawn, so wait for its ack
               pc_nxt    = target;
               state_nxt = DRAIN;
            end else if (i_imem_ack) begin
               buf_pc_nxt    = req_pc;
               buf_instr_nxt = i_imem_rdata;
               state_nxt     = HOLD;
            end
         end
         DRAIN: begin
            if (i_redirect) begin
               pc_nxt = target;
            end
            if (i_imem_ack) begin
               req_pc_nxt = i_redirect ? target : pc;
               state_nxt  = FETCH;
            end
         end
         HOLD: begin
            if (i_redirect) begin
               pc_nxt     = target;
               req_pc_nxt = target;
               state_nxt  = FETCH;
            end else if (i_IFIDWrite) begin
               pc_nxt     = buf_pc + PC_STEP;
               req_pc_nxt = buf_pc + PC_STEP;
               state_nxt  = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_imem_req   = (state == FETCH) || (state == DRAIN);
   assign o_fetch_busy = o_imem_req;
   assign o_imem_addr  = req_pc;
   // a redirect squashes the buffered word combinationally so IF/ID captures a bubble
   assign o_if_valid   = (state == HOLD) && !i_redirect;
   assign o_if_instr   = o_if_valid ? buf_instr : NOP_INSTR;
   assign o_if_pc      = (state == HOLD) ? buf_pc : pc;

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC and issues one request at a time to the instruction memory over a req/ack handshake. Holds the returned word in a one-entry buffer until the IF/ID register accepts it (i_IFIDWrite=1). Handles EX-stage redirects (branch/jump) and presents a NOP bubble whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_7013, bubble word (andi x0,x0,0)
PC_STEP, 4, sequential PC increment

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_IFIDWrite  in  1  1 = IF/ID accepts this cycle; 0 = stall
i_redirect  in  1  taken branch/jump from EX; single-cycle pulse
i_redirect_pc  in  32  redirect target
o_imem_req  out  1  fetch request
o_imem_addr  out  32  fetch address, word aligned
i_imem_ack  in  1  one-cycle pulse; data valid this cycle
i_imem_rdata  in  32  fetched instruction
o_if_pc  out  32  PC to IF/ID
o_if_instr  out  32  instruction to IF/ID
o_if_valid  out  1  o_if_instr is a real instruction
o_fetch_busy  out  1  1 in FETCH or DRAIN

Behaviour:
- Reset state: i_clk and i_reset as decided above. State IDLE, pc=RESET_PC, req_pc=RESET_PC, buffer invalid. Outputs during reset: o_imem_req=0, o_if_valid=0, o_if_instr=NOP_INSTR, o_if_pc=RESET_PC, o_fetch_busy=0.
- States: IDLE, FETCH, HOLD, DRAIN. o_imem_req=1 in FETCH and DRAIN only. o_imem_addr=req_pc.
- Memory contract:
  - Once o_imem_req is asserted, it stays high and o_imem_addr stays stable until i_imem_ack.
  - i_imem_ack outside FETCH/DRAIN is ignored.
- Redirect target: i_redirect_pc[1:0] is forced to 2'b00 before being loaded.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect has priority over every other event in every state.
- IDLE:
  - Next state is FETCH unconditionally.
  - If i_redirect, pc=req_pc=target; otherwise req_pc=pc.
- FETCH:
  - ack & !redirect: buffer {req_pc, rdata}, go to HOLD.
  - ack & redirect: drop the data, pc=req_pc=target, stay in FETCH. A new request is issued the next cycle.
  - !ack & redirect: pc=target, go to DRAIN. req_pc is kept because the outstanding request is committed.
  - !ack & !redirect: stay in FETCH.
- DRAIN:
  - Keep req high at the old req_pc.
  - On ack, discard the data, req_pc=pc, go to FETCH.
  - A further redirect in DRAIN only updates pc.
- HOLD:
  - o_if_valid=1, o_if_pc=buffered pc, o_if_instr=buffered instruction.
  - i_IFIDWrite=1 & !redirect: instruction consumed; pc=req_pc=buf_pc+PC_STEP, go to FETCH.
  - i_IFIDWrite=0: hold all outputs stable.
  - redirect: drop the buffer, pc=req_pc=target, go to FETCH.
- Flush masking:
  - While i_redirect=1, o_if_valid=0 and o_if_instr=NOP_INSTR combinationally, in every state. IF/ID therefore latches a bubble even if it samples on the same edge.
  - Outside HOLD: o_if_valid=0, o_if_instr=NOP_INSTR, o_if_pc=pc.
- Latency:
  - Ack at edge N gives o_if_valid=1 after N.
  - Consume at edge M gives the next request after M.
  - Peak throughput is 1 instruction per 2 cycles with a zero-wait memory. This is by design.
- Reset mid-operation: returns to IDLE immediately. An ack for a request in flight before reset is ignored, because req=0 in IDLE.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - NOP_INSTR constant (shared with IF/ID).
  - fetch_state_t enum {IDLE, FETCH, HOLD, DRAIN}.
  - PC_STEP constant.
- Single module; no sub-module is warranted. Next-PC selection is inline.

Test Plan:
- Reset, then zero-wait memory returns 0x0000_0093 @0: req@0 on the cycle after IDLE. HOLD shows pc=0, instr=0x0000_0093, valid=1. With IFIDWrite=1, the next req is at addr 4.
- Stall: HOLD with IFIDWrite=0 for 3 cycles: outputs stable, req=0. IFIDWrite=1 then causes the next req at pc+4.
- Redirect in HOLD to 0x0000_0102: valid drops to 0 and instr=0x0000_7013 in that cycle. The next req is at 0x0000_0100 (bits [1:0] cleared).
- Redirect in FETCH without ack, target 0x40, memory acks 3 cycles later with 0xDEAD_BEEF: addr stays at the old PC through DRAIN, data is never valid, and the next req is at 0x40.
- Redirect in the same cycle as ack in FETCH: data discarded, req at the target on the next cycle.
- Wrap: redirect to 0xFFFF_FFFC and consume: next req addr 0x0000_0000.
